// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver (8N1) feeding a small show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the sticky parity_err output.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 65,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    logic             rx_meta;
    logic             rxs;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             restart;

    state_t           state, state_nxt;
    logic [3:0]       sc, sc_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic             push;
    logic             stop_err;

`ifdef UART_RX_PARITY_EN
    logic             parity_bad, parity_bad_nxt;
    logic             par_err_set;
`endif

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;
    logic                  drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Free-running divider, re-phased at the start edge so ticks line up with the frame.
    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (restart || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sc        <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            sc        <= sc_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
`ifdef UART_RX_PARITY_EN
            parity_bad <= parity_bad_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        sc_nxt      = sc;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        push        = 1'b0;
        stop_err    = 1'b0;
        restart     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_nxt = parity_bad;
        par_err_set    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_nxt = ST_START;
                    sc_nxt    = '0;
                    restart   = 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_bad_nxt = 1'b0;
`endif
                end
            end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            ST_START: begin
                if (tick) begin
                    if (sc == 4'd7) begin
                        sc_nxt = '0;
                        if (rxs) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt   = ST_DATA;
                            bit_idx_nxt = '0;
                        end
                    end else begin
                        sc_nxt = sc + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (sc == 4'd15) begin
                        sc_nxt    = '0;
                        shift_nxt = {rxs, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            state_nxt = ST_STOP;
`endif
                        end else begin
                            bit_idx_nxt = bit_idx + 3'd1;
                        end
                    end else begin
                        sc_nxt = sc + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (sc == 4'd15) begin
                        sc_nxt         = '0;
                        state_nxt      = ST_STOP;
                        parity_bad_nxt = ^{shift_reg, rxs};
                        par_err_set    = ^{shift_reg, rxs};
                    end else begin
                        sc_nxt = sc + 4'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (sc == 4'd15) begin
                        sc_nxt = '0;
                        if (rxs) begin
                            state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            push = !parity_bad;
`else
                            push = 1'b1;
`endif
                        end else begin
                            state_nxt = ST_BREAK;
                            stop_err  = 1'b1;
                        end
                    end else begin
                        sc_nxt = sc + 4'd1;
                    end
                end
            end
            // A held-low line parks here so it reports one error, not a stream of frames.
            ST_BREAK: begin
                if (rxs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a fresh error in the same cycle beats the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (stop_err) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (par_err_set) begin
            parity_err <= 1'b1;
        end else if (clr_err) begin
            parity_err <= 1'b0;
        end
    end
`endif

    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign irq     = !empty;
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule
